dummy_streamer_buf: RTL and testbench

DUMMY_STREAMER_BUF -- requirements
Module: dummy_streamer_buf

---
 rtl/dummy_streamer_pkg.sv | 14 +
 rtl/dummy_streamer_ram.sv | 33 +++
 rtl/dummy_streamer_buf.sv | 146 ++++++++++++++
 tb/tb_dummy_streamer_buf.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dummy_streamer_pkg.sv
// Shared definitions for the dummy streamer store-then-replay buffer:
// STORE/LOAD state encoding and storage depth derivation.
package dummy_streamer_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_STORE = 1'b0;
    localparam state_t ST_LOAD  = 1'b1;

    function automatic int calc_depth(input int idx_width);
        return 1 << idx_width;
    endfunction

endpackage

// File: rtl/dummy_streamer_ram.sv
// Simple dual-port storage for the streamer: one write port, one synchronous
// read port whose output holds while the read enable is low.
module dummy_streamer_ram
    import dummy_streamer_pkg::*;
#(
    parameter int WIDTH      = 36,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);
    localparam int DEPTH = calc_depth(ADDR_WIDTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dummy_streamer_buf.sv
// Store-then-replay packet buffer: captures one packet from S_AXI, then replays it on M_AXI.
// Define DUMMY_STREAMER_STATUS_EN to expose pkt_len_o and the sticky pkt_ovf_o truncation flag.
module dummy_streamer_buf
    import dummy_streamer_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int STORAGE_IDX_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        S_AXI_TDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_TKEEP,
    input  logic                         S_AXI_TVALID,
    output logic                         S_AXI_TREADY,
    input  logic                         S_AXI_TLAST,
    output logic [DATA_WIDTH-1:0]        M_AXI_TDATA,
    output logic [DATA_WIDTH/8-1:0]      M_AXI_TKEEP,
    output logic                         M_AXI_TVALID,
    input  logic                         M_AXI_TREADY,
    output logic                         M_AXI_TLAST
`ifdef DUMMY_STREAMER_STATUS_EN
    ,
    output logic [STORAGE_IDX_WIDTH:0]   pkt_len_o,
    output logic                         pkt_ovf_o
`endif
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int RAM_WIDTH  = DATA_WIDTH + KEEP_WIDTH;
    localparam logic [STORAGE_IDX_WIDTH-1:0] IDX_ONE = STORAGE_IDX_WIDTH'(1);
    localparam logic [STORAGE_IDX_WIDTH:0]   LEN_ONE = (STORAGE_IDX_WIDTH + 1)'(1);

    state_t                       state_q, state_d;
    logic [STORAGE_IDX_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic [STORAGE_IDX_WIDTH:0]   rd_idx_q, rd_idx_d;
    logic [STORAGE_IDX_WIDTH:0]   pkt_len_q, pkt_len_d;
    logic                         m_valid_q, m_valid_d;
    logic                         m_last_q, m_last_d;
    logic                         s_fire;
    logic                         m_fire;
    logic                         fetch;
    logic                         pkt_end;
    logic [RAM_WIDTH-1:0]         ram_rdata;

    assign S_AXI_TREADY = (state_q == ST_STORE);
    assign s_fire       = S_AXI_TVALID && S_AXI_TREADY;
    assign m_fire       = m_valid_q && M_AXI_TREADY;
    assign pkt_end      = S_AXI_TLAST || (&wr_idx_q);

    // rd_idx_q is the next beat to fetch; a fetch only happens when the output
    // register is free or draining, so a stall leaves the RAM read data untouched.
    assign fetch = (state_q == ST_LOAD) && (!m_valid_q || M_AXI_TREADY) &&
                   (rd_idx_q < pkt_len_q);

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        pkt_len_d = pkt_len_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;

        if (s_fire) begin
            wr_idx_d = wr_idx_q + IDX_ONE;
            if (pkt_end) begin
                pkt_len_d = {1'b0, wr_idx_q} + LEN_ONE;
                rd_idx_d  = '0;
                state_d   = ST_LOAD;
            end
        end

        if (fetch) begin
            rd_idx_d  = rd_idx_q + LEN_ONE;
            m_valid_d = 1'b1;
            m_last_d  = (rd_idx_q == pkt_len_q - LEN_ONE);
        end else if (m_fire) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (m_fire && m_last_q) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            state_d  = ST_STORE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_STORE;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            pkt_len_q <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            pkt_len_q <= pkt_len_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    dummy_streamer_ram #(
        .WIDTH      (RAM_WIDTH),
        .ADDR_WIDTH (STORAGE_IDX_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (s_fire),
        .waddr_i (wr_idx_q),
        .wdata_i ({S_AXI_TKEEP, S_AXI_TDATA}),
        .re_i    (fetch),
        .raddr_i (rd_idx_q[STORAGE_IDX_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    // Data and keep are forced to zero whenever no beat is being presented.
    assign M_AXI_TVALID = m_valid_q;
    assign M_AXI_TLAST  = m_last_q;
    assign M_AXI_TDATA  = m_valid_q ? ram_rdata[DATA_WIDTH-1:0] : '0;
    assign M_AXI_TKEEP  = m_valid_q ? ram_rdata[RAM_WIDTH-1:DATA_WIDTH] : '0;

`ifdef DUMMY_STREAMER_STATUS_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (s_fire && !S_AXI_TLAST && (&wr_idx_q)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign pkt_len_o = pkt_len_q;
    assign pkt_ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_dummy_streamer_buf.sv
// Self-checking bench for dummy_streamer_buf with a 4-beat store (STORAGE_IDX_WIDTH = 2),
// comparing replayed beats against a packet-splitting reference model.
module tb_dummy_streamer_buf;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int IW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] S_AXI_TDATA;
    logic [KW-1:0] S_AXI_TKEEP;
    logic          S_AXI_TVALID;
    logic          S_AXI_TREADY;
    logic          S_AXI_TLAST;
    logic [DW-1:0] M_AXI_TDATA;
    logic [KW-1:0] M_AXI_TKEEP;
    logic          M_AXI_TVALID;
    logic          M_AXI_TREADY;
    logic          M_AXI_TLAST;
`ifdef DUMMY_STREAMER_STATUS_EN
    logic [IW:0]   pkt_len_o;
    logic          pkt_ovf_o;
`endif

    dummy_streamer_buf #(
        .DATA_WIDTH        (DW),
        .STORAGE_IDX_WIDTH (IW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .S_AXI_TDATA  (S_AXI_TDATA),
        .S_AXI_TKEEP  (S_AXI_TKEEP),
        .S_AXI_TVALID (S_AXI_TVALID),
        .S_AXI_TREADY (S_AXI_TREADY),
        .S_AXI_TLAST  (S_AXI_TLAST),
        .M_AXI_TDATA  (M_AXI_TDATA),
        .M_AXI_TKEEP  (M_AXI_TKEEP),
        .M_AXI_TVALID (M_AXI_TVALID),
        .M_AXI_TREADY (M_AXI_TREADY),
        .M_AXI_TLAST  (M_AXI_TLAST)
`ifdef DUMMY_STREAMER_STATUS_EN
        ,
        .pkt_len_o    (pkt_len_o),
        .pkt_ovf_o    (pkt_ovf_o)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] inData[$];
    logic [KW-1:0] inKeep[$];
    logic          inLast[$];
    logic [DW-1:0] expData[$];
    logic [KW-1:0] expKeep[$];
    logic          expLast[$];
    logic [DW-1:0] gotData[$];
    logic [KW-1:0] gotKeep[$];
    logic          gotLast[$];
    int            gotCycle[$];
    bit            expOvf = 1'b0;
    int            expLen = 0;
    int            sIdx;
    int            stallViol;
    int            overlapViol;
    int            latencyViol;
    bit            timedOut;

    // Stimulus queue helpers
    task automatic clearStim();
        inData.delete();
        inKeep.delete();
        inLast.delete();
    endtask

    task automatic pushBeat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        inData.push_back(d);
        inKeep.push_back(k);
        inLast.push_back(l);
    endtask

    task automatic addRandomPacket(input int len);
        for (int i = 0; i < len; i++) begin
            pushBeat($urandom(), KW'($urandom_range(0, (1 << KW) - 1)), (i == len - 1));
        end
    endtask

    // Reference model: the input stream is cut into packets at TLAST, or after
    // DEPTH beats when TLAST has not arrived (the rest forms the next packet).
    task automatic buildExpected();
        int beatInPkt = 0;
        expData.delete();
        expKeep.delete();
        expLast.delete();
        foreach (inData[i]) begin
            expData.push_back(inData[i]);
            expKeep.push_back(inKeep[i]);
            beatInPkt++;
            if (inLast[i] || beatInPkt == DEPTH) begin
                if (!inLast[i]) expOvf = 1'b1;
                expLen = beatInPkt;
                expLast.push_back(1'b1);
                beatInPkt = 0;
            end else begin
                expLast.push_back(1'b0);
            end
        end
    endtask

    // Drives the stimulus queue and collects M-side beats; inputs change and
    // outputs are sampled at the falling edge.
    task automatic runTraffic(input int readyMode, input int validMode, input int outLimit,
                              input int maxCycles);
        int            cyc      = 0;
        int            waitCnt  = 0;
        bit            waiting  = 1'b0;
        bit            curValid = 1'b0;
        bit            holdValid = 1'b0;
        logic [DW-1:0] hData = '0;
        logic [KW-1:0] hKeep = '0;
        logic          hLast = 1'b0;
        buildExpected();
        gotData.delete();
        gotKeep.delete();
        gotLast.delete();
        gotCycle.delete();
        sIdx = 0; stallViol = 0; overlapViol = 0; latencyViol = 0; timedOut = 1'b0;
        forever begin
            @(negedge clk);
            if (holdValid && (M_AXI_TVALID !== 1'b1 || M_AXI_TDATA !== hData ||
                              M_AXI_TKEEP !== hKeep || M_AXI_TLAST !== hLast)) stallViol++;
            if (M_AXI_TVALID === 1'b1 && S_AXI_TREADY === 1'b1) overlapViol++;
            if (waiting) begin
                if (M_AXI_TVALID === 1'b1) begin
                    waiting = 1'b0;
                end else begin
                    waitCnt++;
                    if (waitCnt >= 3) begin
                        latencyViol++;
                        waiting = 1'b0;
                    end
                end
            end
            case (readyMode)
                0:       M_AXI_TREADY = 1'b1;
                1:       M_AXI_TREADY = 1'($urandom_range(0, 1));
                default: M_AXI_TREADY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
            if (sIdx < inData.size()) begin
                if (!curValid) curValid = (validMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                curValid = 1'b0;
            end
            S_AXI_TVALID = curValid;
            S_AXI_TDATA  = curValid ? inData[sIdx] : '0;
            S_AXI_TKEEP  = curValid ? inKeep[sIdx] : '0;
            S_AXI_TLAST  = curValid ? inLast[sIdx] : 1'b0;
            #1;
            if (S_AXI_TVALID && S_AXI_TREADY) begin
                if (expLast[sIdx]) begin
                    waiting = 1'b1;
                    waitCnt = 0;
                end
                sIdx++;
                curValid = 1'b0;
            end
            if (M_AXI_TVALID && M_AXI_TREADY) begin
                gotData.push_back(M_AXI_TDATA);
                gotKeep.push_back(M_AXI_TKEEP);
                gotLast.push_back(M_AXI_TLAST);
                gotCycle.push_back(cyc);
            end
            holdValid = M_AXI_TVALID && !M_AXI_TREADY;
            hData = M_AXI_TDATA;
            hKeep = M_AXI_TKEEP;
            hLast = M_AXI_TLAST;
            cyc++;
            if (outLimit > 0 && gotData.size() >= outLimit) break;
            if (sIdx == inData.size() && gotData.size() == expData.size()) break;
            if (cyc >= maxCycles) begin
                timedOut = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        S_AXI_TVALID = 1'b0;
        S_AXI_TLAST  = 1'b0;
        M_AXI_TREADY = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        S_AXI_TVALID = 1'b0; S_AXI_TDATA = '0; S_AXI_TKEEP = '0; S_AXI_TLAST = 1'b0;
        M_AXI_TREADY = 1'b0;
        expOvf = 1'b0;
        expLen = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (S_AXI_TREADY !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_s_tready: got %b, expected 1", S_AXI_TREADY);
        end
        checks++;
        if (M_AXI_TVALID !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_m_tvalid: got %b, expected 0", M_AXI_TVALID);
        end
        checks++;
        if (M_AXI_TDATA !== '0 || M_AXI_TKEEP !== '0) begin
            failures++;
            $display("[TB] FAIL reset_m_data: got data=%h keep=%h, expected 0/0", M_AXI_TDATA, M_AXI_TKEEP);
        end
        checks++;
        if (M_AXI_TLAST !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_m_tlast: got %b, expected 0", M_AXI_TLAST);
        end
`ifdef DUMMY_STREAMER_STATUS_EN
        checks++;
        if (pkt_ovf_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_ovf: got %b, expected 0", pkt_ovf_o);
        end
`endif
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_packet();
        clearStim();
        pushBeat(32'h11, 4'hF, 1'b0);
        pushBeat(32'h22, 4'hF, 1'b0);
        pushBeat(32'h33, 4'hF, 1'b0);
        pushBeat(32'h44, 4'hF, 1'b1);
        runTraffic(0, 0, 0, 200);
        checks++;
        if (timedOut || gotData.size() != 4) begin
            failures++; $display("[TB] FAIL basic_count: got %0d beats (timeout=%0d), expected 4", gotData.size(), timedOut);
        end
        for (int i = 0; i < gotData.size() && i < 4; i++) begin
            checks++;
            if (gotData[i] !== 32'h11 * (i + 1) || gotKeep[i] !== 4'hF || gotLast[i] !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL basic_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=f last=%b",
                         i, gotData[i], gotKeep[i], gotLast[i], 32'h11 * (i + 1), (i == 3));
            end
        end
        for (int i = 1; i < gotCycle.size(); i++) begin
            checks++;
            if (gotCycle[i] != gotCycle[i-1] + 1) begin
                failures++; $display("[TB] FAIL basic_back_to_back: beat %0d at cycle %0d, expected %0d", i, gotCycle[i], gotCycle[i-1] + 1);
            end
        end
        checks++;
        if (stallViol != 0 || overlapViol != 0 || latencyViol != 0) begin
            failures++; $display("[TB] FAIL basic_protocol: stall=%0d overlap=%0d latency=%0d, expected 0/0/0", stallViol, overlapViol, latencyViol);
        end
        checks++;
        if (S_AXI_TREADY !== 1'b1) begin
            failures++; $display("[TB] FAIL basic_return_store: s_tready=%b, expected 1", S_AXI_TREADY);
        end
    endtask

    task automatic test_stall_pattern();
        clearStim();
        pushBeat(32'h11, 4'hF, 1'b0);
        pushBeat(32'h22, 4'hF, 1'b0);
        pushBeat(32'h33, 4'hF, 1'b0);
        pushBeat(32'h44, 4'hF, 1'b1);
        runTraffic(2, 0, 0, 200);
        checks++;
        if (timedOut || gotData.size() != expData.size()) begin
            failures++; $display("[TB] FAIL stall_count: got %0d beats (timeout=%0d), expected %0d", gotData.size(), timedOut, expData.size());
        end
        for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
            checks++;
            if (gotData[i] !== expData[i] || gotKeep[i] !== expKeep[i] || gotLast[i] !== expLast[i]) begin
                failures++;
                $display("[TB] FAIL stall_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, gotData[i], gotKeep[i], gotLast[i], expData[i], expKeep[i], expLast[i]);
            end
        end
        checks++;
        if (stallViol != 0 || overlapViol != 0 || latencyViol != 0) begin
            failures++; $display("[TB] FAIL stall_protocol: stall=%0d overlap=%0d latency=%0d, expected 0/0/0", stallViol, overlapViol, latencyViol);
        end
    endtask

    task automatic test_single_beat();
        clearStim();
        pushBeat(32'hA5, 4'h3, 1'b1);
        runTraffic(0, 0, 0, 100);
        checks++;
        if (timedOut || gotData.size() != 1) begin
            failures++; $display("[TB] FAIL single_count: got %0d beats (timeout=%0d), expected 1", gotData.size(), timedOut);
        end else begin
            checks++;
            if (gotData[0] !== 32'hA5 || gotKeep[0] !== 4'h3 || gotLast[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL single_beat: got data=%h keep=%h last=%b, expected data=a5 keep=3 last=1", gotData[0], gotKeep[0], gotLast[0]);
            end
        end
        checks++;
        if (S_AXI_TREADY !== 1'b1 || latencyViol != 0) begin
            failures++; $display("[TB] FAIL single_return: s_tready=%b latency=%0d, expected 1/0", S_AXI_TREADY, latencyViol);
        end
`ifdef DUMMY_STREAMER_STATUS_EN
        checks++;
        if (pkt_len_o !== (IW+1)'(expLen) || pkt_ovf_o !== expOvf) begin
            failures++; $display("[TB] FAIL single_status: len=%0d ovf=%b, expected %0d/%b", pkt_len_o, pkt_ovf_o, expLen, expOvf);
        end
`endif
    endtask

    task automatic test_overflow();
        clearStim();
        for (int i = 1; i <= 6; i++) pushBeat(32'h100 + i, 4'hF, (i == 6));
        runTraffic(1, 0, 0, 400);
        checks++;
        if (timedOut || gotData.size() != 6) begin
            failures++; $display("[TB] FAIL ovf_count: got %0d beats (timeout=%0d), expected 6", gotData.size(), timedOut);
        end
        for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
            checks++;
            if (gotData[i] !== expData[i] || gotKeep[i] !== expKeep[i] || gotLast[i] !== expLast[i]) begin
                failures++;
                $display("[TB] FAIL ovf_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, gotData[i], gotKeep[i], gotLast[i], expData[i], expKeep[i], expLast[i]);
            end
        end
        checks++;
        if (gotLast.size() == 6 && (gotLast[3] !== 1'b1 || gotLast[5] !== 1'b1)) begin
            failures++; $display("[TB] FAIL ovf_tlast_positions: beat4=%b beat6=%b, expected 1/1", gotLast[3], gotLast[5]);
        end
        checks++;
        if (stallViol != 0 || overlapViol != 0 || latencyViol != 0) begin
            failures++; $display("[TB] FAIL ovf_protocol: stall=%0d overlap=%0d latency=%0d, expected 0/0/0", stallViol, overlapViol, latencyViol);
        end
`ifdef DUMMY_STREAMER_STATUS_EN
        checks++;
        if (pkt_len_o !== (IW+1)'(expLen) || pkt_ovf_o !== expOvf) begin
            failures++; $display("[TB] FAIL ovf_status: len=%0d ovf=%b, expected %0d/%b", pkt_len_o, pkt_ovf_o, expLen, expOvf);
        end
`endif
    endtask

    task automatic test_random(input int validMode);
        clearStim();
        for (int p = 0; p < 10; p++) addRandomPacket($urandom_range(1, 6));
        runTraffic(1, validMode, 0, 3000);
        checks++;
        if (timedOut || gotData.size() != expData.size()) begin
            failures++; $display("[TB] FAIL random%0d_count: got %0d beats (timeout=%0d), expected %0d", validMode, gotData.size(), timedOut, expData.size());
        end
        for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
            checks++;
            if (gotData[i] !== expData[i] || gotKeep[i] !== expKeep[i] || gotLast[i] !== expLast[i]) begin
                failures++;
                $display("[TB] FAIL random%0d_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         validMode, i, gotData[i], gotKeep[i], gotLast[i], expData[i], expKeep[i], expLast[i]);
            end
        end
        checks++;
        if (stallViol != 0 || overlapViol != 0 || latencyViol != 0) begin
            failures++; $display("[TB] FAIL random%0d_protocol: stall=%0d overlap=%0d latency=%0d, expected 0/0/0", validMode, stallViol, overlapViol, latencyViol);
        end
`ifdef DUMMY_STREAMER_STATUS_EN
        checks++;
        if (pkt_len_o !== (IW+1)'(expLen) || pkt_ovf_o !== expOvf) begin
            failures++; $display("[TB] FAIL random%0d_status: len=%0d ovf=%b, expected %0d/%b", validMode, pkt_len_o, pkt_ovf_o, expLen, expOvf);
        end
`endif
    endtask

    task automatic test_reset_mid_load();
        clearStim();
        pushBeat(32'hC1, 4'hF, 1'b0);
        pushBeat(32'hC2, 4'hF, 1'b0);
        pushBeat(32'hC3, 4'hF, 1'b1);
        runTraffic(0, 0, 2, 200);
        checks++;
        if (M_AXI_TVALID !== 1'b1) begin
            failures++; $display("[TB] FAIL midload_third_pending: m_tvalid=%b, expected 1", M_AXI_TVALID);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (M_AXI_TVALID !== 1'b0 || M_AXI_TLAST !== 1'b0 || M_AXI_TDATA !== '0) begin
            failures++; $display("[TB] FAIL midload_async_clear: valid=%b last=%b data=%h, expected 0/0/0", M_AXI_TVALID, M_AXI_TLAST, M_AXI_TDATA);
        end
        expOvf = 1'b0;
        expLen = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (S_AXI_TREADY !== 1'b1) begin
            failures++; $display("[TB] FAIL midload_s_tready: got %b, expected 1", S_AXI_TREADY);
        end
        clearStim();
        addRandomPacket(2);
        runTraffic(0, 0, 0, 200);
        checks++;
        if (timedOut || gotData.size() != 2) begin
            failures++; $display("[TB] FAIL midload_next_count: got %0d beats (timeout=%0d), expected 2", gotData.size(), timedOut);
        end
        for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
            checks++;
            if (gotData[i] !== expData[i] || gotKeep[i] !== expKeep[i] || gotLast[i] !== expLast[i]) begin
                failures++;
                $display("[TB] FAIL midload_next_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, gotData[i], gotKeep[i], gotLast[i], expData[i], expKeep[i], expLast[i]);
            end
        end
`ifdef DUMMY_STREAMER_STATUS_EN
        checks++;
        if (pkt_ovf_o !== 1'b0) begin
            failures++; $display("[TB] FAIL midload_ovf_cleared: got %b, expected 0", pkt_ovf_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_stall_pattern();
        test_single_beat();
        test_overflow();
        test_random(1);
        test_random(0);
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
